// File: rtl/digital_projection.sv
// digital_projection
//   Upstream stage of the digit recogniser. Builds row and column projections of
//   the binarised pixel stream and extracts the borders of the digit regions.
//   Borders land in two small register-file RAMs that the recogniser reads back
//   asynchronously while project_done_flag is high.
//
//   Frame phases (frame_cnt): 0 = projecting (ACCUM), 1 = column scan then
//   publish, 2 = results held. Then the next eof restarts projection.
//
// Ports
//   clk, rst                   pixel clock, synchronous active-high reset
//   pix_valid, xpos, ypos      pixel strobe and coordinates
//   monoc                      binarised pixel, 0 = ink, 1 = background
//   row_border_addr/_data      row border RAM read (2k = top, 2k+1 = bottom)
//   col_border_addr/_data      column border RAM read (2k = left, 2k+1 = right)
//   num_row, num_col           segments found in the last projected frame
//   frame_cnt                  frame phase 0 -> 1 -> 2 -> 0
//   project_done_flag          borders and counts are valid
//
// Build option
//   PROJ_NOISE_FILTER_EN : when defined, segments shorter than MIN_SEG pixels
//   are discarded at close time (rows and columns). Undefined: every segment
//   of length >= 1 is kept.
module digital_projection #(
  parameter int H_PIXEL = 480,
  parameter int V_PIXEL = 272,
  parameter int MAX_ROW = 1,
  parameter int MAX_COL = 4,
  parameter int MIN_SEG = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        monoc,
  input  logic [10:0] row_border_addr,
  output logic [10:0] row_border_data,
  input  logic [10:0] col_border_addr,
  output logic [10:0] col_border_data,
  output logic [3:0]  num_row,
  output logic [3:0]  num_col,
  output logic [1:0]  frame_cnt,
  output logic        project_done_flag
);

`ifdef PROJ_NOISE_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif
  localparam int SEG_MIN_LEN = FILTER_ON ? MIN_SEG : 1;

  localparam int IDX_W = (H_PIXEL > 1) ? $clog2(H_PIXEL) : 1;
  localparam int RRA_W = $clog2(2 * MAX_ROW);
  localparam int CRA_W = $clog2(2 * MAX_COL);

  localparam logic [10:0] H_LAST      = 11'(H_PIXEL - 1);
  localparam logic [10:0] H_END       = 11'(H_PIXEL);
  localparam logic [10:0] V_LAST      = 11'(V_PIXEL - 1);
  localparam logic [10:0] ROW_ENTRIES = 11'(2 * MAX_ROW);
  localparam logic [10:0] COL_ENTRIES = 11'(2 * MAX_COL);
  localparam logic [3:0]  MAX_ROW_C   = 4'(MAX_ROW);
  localparam logic [3:0]  MAX_COL_C   = 4'(MAX_COL);

  typedef enum logic [1:0] {S_WAIT, S_ACCUM, S_SCAN, S_DONE} state_t;

  // Segment length check applied whenever a row or column closes.
  function automatic logic seg_keep(input logic [10:0] s, input logic [10:0] e);
    int len;
    len = int'(e) - int'(s) + 1;
    return len >= SEG_MIN_LEN;
  endfunction

  state_t      state_q, state_d;
  logic [1:0]  frame_cnt_q, frame_cnt_d;
  logic        done_q, done_d;
  logic [3:0]  num_row_q, num_row_d;
  logic [3:0]  num_col_q, num_col_d;
  logic [3:0]  rcnt_q, rcnt_d;
  logic [3:0]  ccnt_q, ccnt_d;
  logic        line_hit_q, line_hit_d;
  logic        prev_row_q, prev_row_d;
  logic [10:0] top_q, top_d;
  logic        prev_col_q, prev_col_d;
  logic [10:0] left_q, left_d;
  logic [10:0] scan_idx_q, scan_idx_d;

  logic [H_PIXEL-1:0] col_hit_q;
  logic [10:0]        row_ram_q [2*MAX_ROW];
  logic [10:0]        col_ram_q [2*MAX_COL];

  logic        eol, eof, pix_ink, hit_now, scan_bit;
  logic        row_close, row_we, col_close, col_we, col_clr, scan_exit;
  logic [10:0] row_lo, row_hi, col_lo, col_hi;

  assign eol      = pix_valid && (xpos == H_LAST);
  assign eof      = eol && (ypos == V_LAST);
  assign pix_ink  = pix_valid && !monoc;
  assign hit_now  = line_hit_q | pix_ink;
  assign scan_bit = col_hit_q[scan_idx_q[IDX_W-1:0]];

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    done_d      = done_q;
    num_row_d   = num_row_q;
    num_col_d   = num_col_q;
    rcnt_d      = rcnt_q;
    ccnt_d      = ccnt_q;
    line_hit_d  = line_hit_q;
    prev_row_d  = prev_row_q;
    top_d       = top_q;
    prev_col_d  = prev_col_q;
    left_d      = left_q;
    scan_idx_d  = scan_idx_q;
    row_close   = 1'b0;
    row_lo      = top_q;
    row_hi      = '0;
    col_close   = 1'b0;
    col_lo      = left_q;
    col_hi      = '0;
    col_clr     = 1'b0;
    scan_exit   = 1'b0;
    row_we      = 1'b0;
    col_we      = 1'b0;

    // Outside WAIT every eof advances the phase; state handlers refine it.
    if (eof && state_q != S_WAIT)
      frame_cnt_d = (frame_cnt_q == 2'd2) ? 2'd0 : frame_cnt_q + 2'd1;

    unique case (state_q)
      S_WAIT: begin
        if (eof) begin
          state_d    = S_ACCUM;
          rcnt_d     = '0;
          ccnt_d     = '0;
          line_hit_d = 1'b0;
          prev_row_d = 1'b0;
        end
      end
      S_ACCUM: begin
        if (pix_valid) line_hit_d = hit_now;
        if (eol) begin
          line_hit_d = 1'b0;
          prev_row_d = hit_now;
          if (hit_now && !prev_row_q) top_d = ypos;
          if (!hit_now && prev_row_q) begin
            row_close = 1'b1;
            row_lo    = top_q;
            row_hi    = ypos - 11'd1;
          end else if (eof && hit_now) begin
            // A row still open on the last line closes at the frame bottom.
            row_close = 1'b1;
            row_lo    = prev_row_q ? top_q : ypos;
            row_hi    = V_LAST;
          end
        end
        if (eof) begin
          state_d    = S_SCAN;
          scan_idx_d = '0;
          prev_col_d = 1'b0;
        end
      end
      S_SCAN: begin
        if (scan_idx_q < H_END) begin
          col_clr    = 1'b1;
          prev_col_d = scan_bit;
          scan_idx_d = scan_idx_q + 11'd1;
          if (scan_bit && !prev_col_q) left_d = scan_idx_q;
          if (!scan_bit && prev_col_q) begin
            col_close = 1'b1;
            col_lo    = left_q;
            col_hi    = scan_idx_q - 11'd1;
          end
        end else begin
          // Extra cycle past the last column closes a column touching the edge.
          if (prev_col_q) begin
            col_close = 1'b1;
            col_lo    = left_q;
            col_hi    = H_LAST;
          end
          scan_exit = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (eof && frame_cnt_q == 2'd2) begin
          state_d    = S_ACCUM;
          done_d     = 1'b0;
          rcnt_d     = '0;
          ccnt_d     = '0;
          line_hit_d = 1'b0;
          prev_row_d = 1'b0;
        end
      end
      default: state_d = S_WAIT;
    endcase

    // Saturating segment recording: full tables drop further segments.
    if (row_close && seg_keep(row_lo, row_hi) && rcnt_q < MAX_ROW_C) begin
      row_we = 1'b1;
      rcnt_d = rcnt_q + 4'd1;
    end
    if (col_close && seg_keep(col_lo, col_hi) && ccnt_q < MAX_COL_C) begin
      col_we = 1'b1;
      ccnt_d = ccnt_q + 4'd1;
    end

    if (scan_exit) begin
      num_row_d = rcnt_d;
      num_col_d = ccnt_d;
      done_d    = (rcnt_d != 4'd0) && (ccnt_d != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_WAIT;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      num_row_q   <= '0;
      num_col_q   <= '0;
      rcnt_q      <= '0;
      ccnt_q      <= '0;
      line_hit_q  <= 1'b0;
      prev_row_q  <= 1'b0;
      top_q       <= '0;
      prev_col_q  <= 1'b0;
      left_q      <= '0;
      scan_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      done_q      <= done_d;
      num_row_q   <= num_row_d;
      num_col_q   <= num_col_d;
      rcnt_q      <= rcnt_d;
      ccnt_q      <= ccnt_d;
      line_hit_q  <= line_hit_d;
      prev_row_q  <= prev_row_d;
      top_q       <= top_d;
      prev_col_q  <= prev_col_d;
      left_q      <= left_d;
      scan_idx_q  <= scan_idx_d;
    end
  end

  // Column bitmap: set during projection, read-and-clear during the scan.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_hit_q <= '0;
    end else begin
      if (col_clr)
        col_hit_q[scan_idx_q[IDX_W-1:0]] <= 1'b0;
      if (state_q == S_ACCUM && pix_ink && xpos < H_END)
        col_hit_q[xpos[IDX_W-1:0]] <= 1'b1;
    end
  end

  // Border RAMs: each close writes the start/end pair in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2 * MAX_ROW; k++) row_ram_q[k] <= '0;
      for (int k = 0; k < 2 * MAX_COL; k++) col_ram_q[k] <= '0;
    end else begin
      if (row_we) begin
        row_ram_q[RRA_W'({rcnt_q, 1'b0})] <= row_lo;
        row_ram_q[RRA_W'({rcnt_q, 1'b1})] <= row_hi;
      end
      if (col_we) begin
        col_ram_q[CRA_W'({ccnt_q, 1'b0})] <= col_lo;
        col_ram_q[CRA_W'({ccnt_q, 1'b1})] <= col_hi;
      end
    end
  end

  assign row_border_data = (row_border_addr < ROW_ENTRIES) ?
                           row_ram_q[row_border_addr[RRA_W-1:0]] : '0;
  assign col_border_data = (col_border_addr < COL_ENTRIES) ?
                           col_ram_q[col_border_addr[CRA_W-1:0]] : '0;

  assign num_row           = num_row_q;
  assign num_col           = num_col_q;
  assign frame_cnt         = frame_cnt_q;
  assign project_done_flag = done_q;

endmodule

// File: tb/tb_digital_projection.sv
module tb_digital_projection;
  localparam int H = 32;
  localparam int V = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [10:0] xpos, ypos;
  logic        monoc;
  logic [10:0] row_border_addr, col_border_addr;
  logic [10:0] row_border_data, col_border_data;
  logic [3:0]  num_row, num_col;
  logic [1:0]  frame_cnt;
  logic        project_done_flag;

  int n_total = 0;
  int n_bad   = 0;

  int rx0[8], rx1[8], ry0[8], ry1[8];
  int nrect;
  logic [1:0] mid_fc;
  logic       mid_done;

  digital_projection #(.H_PIXEL(H), .V_PIXEL(V), .MAX_ROW(2), .MAX_COL(4), .MIN_SEG(3)) dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .xpos(xpos), .ypos(ypos), .monoc(monoc),
    .row_border_addr(row_border_addr), .row_border_data(row_border_data),
    .col_border_addr(col_border_addr), .col_border_data(col_border_data),
    .num_row(num_row), .num_col(num_col), .frame_cnt(frame_cnt),
    .project_done_flag(project_done_flag)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_rects();
    nrect = 0;
  endtask

  task automatic add_rect(input int x0, input int x1, input int y0, input int y1);
    rx0[nrect] = x0; rx1[nrect] = x1; ry0[nrect] = y0; ry1[nrect] = y1;
    nrect++;
  endtask

  function automatic logic ink(input int x, input int y);
    for (int r = 0; r < nrect; r++)
      if (x >= rx0[r] && x <= rx1[r] && y >= ry0[r] && y <= ry1[r]) return 1'b1;
    return 1'b0;
  endfunction

  // One full frame; each line starts with an invalid cycle that carries
  // eof-like coordinates and ink, which the DUT must ignore.
  task automatic run_frame();
    for (int y = 0; y < V; y++) begin
      @(negedge clk);
      pix_valid = 1'b0; xpos = 11'(H - 1); ypos = 11'(V - 1); monoc = 1'b0;
      for (int x = 0; x < H; x++) begin
        @(negedge clk);
        if (y == 2 && x == 0) begin
          mid_fc   = frame_cnt;
          mid_done = project_done_flag;
        end
        pix_valid = 1'b1; xpos = 11'(x); ypos = 11'(y); monoc = ~ink(x, y);
      end
    end
    @(negedge clk);
    pix_valid = 1'b0; monoc = 1'b1;
  endtask

  task automatic chk_row(input string tag, input int a, input int exp);
    row_border_addr = 11'(a);
    #1;
    check_val(tag, 32'(row_border_data), 32'(exp));
  endtask

  task automatic chk_col(input string tag, input int a, input int exp);
    col_border_addr = 11'(a);
    #1;
    check_val(tag, 32'(col_border_data), 32'(exp));
  endtask

  // Runs the SCAN frame and the hold frame, checking phase and flag in each.
  task automatic result_frames(input string tag, input logic exp_done);
    run_frame();
    check_val({tag, "_mid_fc"}, 32'(mid_fc), 1);
    check_val({tag, "_mid_done"}, 32'(mid_done), 32'(exp_done));
    check_val({tag, "_fc2"}, 32'(frame_cnt), 2);
    check_val({tag, "_done2"}, 32'(project_done_flag), 32'(exp_done));
  endtask

  initial begin
    rst = 1'b1; pix_valid = 1'b0; xpos = '0; ypos = '0; monoc = 1'b1;
    row_border_addr = '0; col_border_addr = '0;
    clear_rects();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_val("rst_num_row", 32'(num_row), 0);
    check_val("rst_num_col", 32'(num_col), 0);
    check_val("rst_fc", 32'(frame_cnt), 0);
    check_val("rst_done", 32'(project_done_flag), 0);
    chk_row("rst_row0", 0, 0);
    chk_col("rst_col0", 0, 0);

    // Test 1: single block
    add_rect(4, 9, 3, 10);
    run_frame();
    check_val("t1_wait_fc", 32'(frame_cnt), 0);
    run_frame();
    check_val("t1_accum_fc", 32'(frame_cnt), 1);
    check_val("t1_accum_done", 32'(project_done_flag), 0);
    result_frames("t1", 1'b1);
    check_val("t1_num_row", 32'(num_row), 1);
    check_val("t1_num_col", 32'(num_col), 1);
    chk_row("t1_row0", 0, 3);
    chk_row("t1_row1", 1, 10);
    chk_col("t1_col0", 0, 4);
    chk_col("t1_col1", 1, 9);
    chk_row("t1_row_oob", 4, 0);
    run_frame();
    check_val("t1_wrap_fc", 32'(frame_cnt), 0);
    check_val("t1_wrap_done", 32'(project_done_flag), 0);

    // Test 2: three columns
    clear_rects();
    add_rect(2, 5, 5, 8); add_rect(10, 13, 5, 8); add_rect(20, 25, 5, 8);
    run_frame();
    result_frames("t2", 1'b1);
    check_val("t2_num_col", 32'(num_col), 3);
    check_val("t2_num_row", 32'(num_row), 1);
    chk_col("t2_c0", 0, 2);  chk_col("t2_c1", 1, 5);
    chk_col("t2_c2", 2, 10); chk_col("t2_c3", 3, 13);
    chk_col("t2_c4", 4, 20); chk_col("t2_c5", 5, 25);
    chk_row("t2_r0", 0, 5);  chk_row("t2_r1", 1, 8);
    run_frame();

    // Test 3: ink on all four frame edges
    clear_rects();
    add_rect(0, 0, 0, 0); add_rect(28, 31, 12, 15);
    run_frame();
    result_frames("t3", 1'b1);
    check_val("t3_num_row", 32'(num_row), 2);
    check_val("t3_num_col", 32'(num_col), 2);
    chk_row("t3_r0", 0, 0);  chk_row("t3_r1", 1, 0);
    chk_row("t3_r2", 2, 12); chk_row("t3_r3", 3, 15);
    chk_col("t3_c0", 0, 0);  chk_col("t3_c1", 1, 0);
    chk_col("t3_c2", 2, 28); chk_col("t3_c3", 3, 31);
    run_frame();

    // Test 4: five columns, three rows -> both counts saturate
    clear_rects();
    add_rect(1, 1, 2, 3); add_rect(4, 5, 2, 3); add_rect(8, 8, 6, 6);
    add_rect(12, 13, 10, 10); add_rect(20, 22, 2, 3);
    run_frame();
    result_frames("t4", 1'b1);
    check_val("t4_num_col", 32'(num_col), 4);
    check_val("t4_num_row", 32'(num_row), 2);
    chk_col("t4_c6", 6, 12); chk_col("t4_c7", 7, 13);
    chk_col("t4_c8", 8, 0);
    chk_row("t4_r2", 2, 6);  chk_row("t4_r3", 3, 6);
    run_frame();

    // Blank frame: nothing found, flag stays low
    clear_rects();
    run_frame();
    result_frames("blank", 1'b0);
    check_val("blank_num_row", 32'(num_row), 0);
    check_val("blank_num_col", 32'(num_col), 0);
    run_frame();

    // Test 6: narrow column next to a wide one
    add_rect(7, 8, 4, 9); add_rect(12, 16, 4, 9);
    run_frame();
    result_frames("t6", 1'b1);
`ifdef PROJ_NOISE_FILTER_EN
    check_val("t6_num_col", 32'(num_col), 1);
    chk_col("t6_c0", 0, 12); chk_col("t6_c1", 1, 16);
`else
    check_val("t6_num_col", 32'(num_col), 2);
    chk_col("t6_c0", 0, 7);  chk_col("t6_c1", 1, 8);
    chk_col("t6_c2", 2, 12); chk_col("t6_c3", 3, 16);
`endif
    run_frame();

    // Test 5: reset during SCAN
    clear_rects();
    add_rect(4, 9, 3, 10);
    run_frame();
    check_val("t5_scan_fc", 32'(frame_cnt), 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("t5_rst_fc", 32'(frame_cnt), 0);
    check_val("t5_rst_done", 32'(project_done_flag), 0);
    check_val("t5_rst_nrow", 32'(num_row), 0);
    check_val("t5_rst_ncol", 32'(num_col), 0);
    chk_col("t5_rst_c0", 0, 0);
    run_frame();
    check_val("t5_wait_mid_fc", 32'(mid_fc), 0);
    check_val("t5_wait_fc", 32'(frame_cnt), 0);
    run_frame();
    check_val("t5_accum_fc", 32'(frame_cnt), 1);
    result_frames("t5", 1'b1);
    check_val("t5_num_row", 32'(num_row), 1);
    chk_col("t5_c1", 1, 9);
    run_frame();
    check_val("t5_wrap_fc", 32'(frame_cnt), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
